serial_sub_nbit: RTL and testbench

//  Multi-cycle N-bit subtractor: d = x - y - bin, computed DIGIT bits per clock, LSB first.

---
 rtl/serial_sub_nbit_pkg.sv | 20 ++
 rtl/serial_sub_nbit_sub_digit.sv | 24 ++
 rtl/serial_sub_nbit.sv | 152 +++++++++++++++
 tb/tb_serial_sub_nbit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_nbit_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and a
// constant-evaluable ceil(log2) used to size the step counter.
package serial_sub_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_nbit_sub_digit.sv
// Combinational ripple of DIGIT 1-bit full-subtractor cells, LSB first:
// {bo, diff} = a - b - bi.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] diff,
  output logic             bo
);

  logic [DIGIT:0] w_brw;

  assign w_brw[0] = bi;

  for (genvar k = 0; k < DIGIT; k++) begin : g_cell
    assign diff[k]    = a[k] ^ b[k] ^ w_brw[k];
    assign w_brw[k+1] = (~(a[k] ^ b[k]) & w_brw[k]) | (~a[k] & b[k]);
  end

  assign bo = w_brw[DIGIT];

endmodule

// File: rtl/serial_sub_nbit.sv
// Multi-cycle d = x - y - bin, DIGIT bits per clock LSB first, with a
// start/busy/done handshake and registered borrow, overflow and zero flags.
module serial_sub_nbit
  import serial_sub_nbit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? clog2(STEPS) : 1;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_sub_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_x_sh;
  logic [WIDTH-1:0] r_y_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_x_msb;
  logic             r_y_msb;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic [DIGIT-1:0] w_diff;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a    (r_x_sh[DIGIT-1:0]),
    .b    (r_y_sh[DIGIT-1:0]),
    .bi   (r_brw),
    .diff (w_diff),
    .bo   (w_bo)
  );

  assign w_last = (r_cnt == CNT_W'(STEPS - 1));

  // Only the upper WIDTH-DIGIT bits of the partial result need storing: the
  // newest slice enters from the MSB end and the final slice completes d.
  if (DIGIT < WIDTH) begin : g_acc
    logic [WIDTH-DIGIT-1:0] r_acc;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_acc_next[WIDTH-1:DIGIT];
      end
    end

    assign w_acc_next = {w_diff, r_acc};
  end else begin : g_acc_none
    assign w_acc_next = w_diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // a signal unassigned and no latch is inferred.
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register here sees
    // the pre-edge value of every other register regardless of statement order.
    if (rst) begin
      r_x_sh  <= '0;
      r_y_sh  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_x_msb <= 1'b0;
      r_y_msb <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x_sh  <= x;
            r_y_sh  <= y;
            r_brw   <= bin;
            r_cnt   <= '0;
            r_x_msb <= x[WIDTH-1];
            r_y_msb <= y[WIDTH-1];
          end
        end
        ST_RUN: begin
          r_x_sh <= r_x_sh >> DIGIT;
          r_y_sh <= r_y_sh >> DIGIT;
          r_brw  <= w_bo;
          r_cnt  <= r_cnt + 1'b1;
          // Results change only on completion and hold across later starts.
          if (w_last) begin
            r_d    <= w_acc_next;
            r_bout <= w_bo;
            r_ovf  <= (r_x_msb != r_y_msb) && (w_acc_next[WIDTH-1] != r_x_msb);
            r_zero <= (w_acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Bench for serial_sub_nbit: four instances (DIGIT 1,2,4,8) share one stimulus
// stream and are compared every cycle against a timestamp/arithmetic model.
module tb_serial_sub_nbit;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst, start, bin;
  logic [7:0] x, y;

  logic       busy_a [NI];
  logic       done_a [NI];
  logic [7:0] d_a    [NI];
  logic       bout_a [NI];
  logic       ovf_a  [NI];
  logic       zero_a [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_sub_nbit #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .bin   (bin),
      .busy  (busy_a[g]),
      .done  (done_a[g]),
      .d     (d_a[g]),
      .bout  (bout_a[g]),
      .ovf   (ovf_a[g]),
      .zero  (zero_a[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result packed as {bout, ovf, zero, d}, from plain 9-bit arithmetic.
  function automatic logic [10:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] full;
    logic [7:0] r;
    full = {1'b0, a} - {1'b0, b} - {8'd0, c};
    r    = full[7:0];
    return {full[8], (a[7] != b[7]) && (r[7] != a[7]), (r == 8'd0), r};
  endfunction

  function automatic int steps_of(input int i);
    return 8 >> i;
  endfunction

  // Model: edge index of each accepted start, earliest edge a new start may be
  // taken, pending result and the visible (held) result.
  int          e_cnt = 0;
  int          n_acc0 = 0;
  bit          m_act  [NI] = '{default: 1'b0};
  int          m_t0   [NI] = '{default: 0};
  int          m_free [NI] = '{default: 0};
  logic [10:0] m_pend [NI] = '{default: '0};
  logic [10:0] m_res  [NI] = '{default: '0};

  always @(posedge clk) begin : model
    int e;
    e = e_cnt + 1;
    e_cnt <= e;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_act[i]  <= 1'b0;
        m_free[i] <= e + 1;
        m_res[i]  <= '0;
      end else begin
        if (m_act[i] && e == m_t0[i] + steps_of(i)) m_res[i] <= m_pend[i];
        if (start && e >= m_free[i]) begin
          m_act[i]  <= 1'b1;
          m_t0[i]   <= e;
          m_free[i] <= e + steps_of(i) + 2;
          m_pend[i] <= ref_sub(x, y, bin);
          if (i == 0) n_acc0 <= n_acc0 + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        logic exp_busy, exp_done;
        exp_busy = m_act[i] && e_cnt >= m_t0[i] && e_cnt < m_t0[i] + steps_of(i);
        exp_done = m_act[i] && e_cnt == m_t0[i] + steps_of(i);
        check($sformatf("busy[D%0d]", 1 << i), busy_a[i], exp_busy);
        check($sformatf("done[D%0d]", 1 << i), done_a[i], exp_done);
        check($sformatf("d[D%0d]", 1 << i),    d_a[i],    m_res[i][7:0]);
        check($sformatf("zero[D%0d]", 1 << i), zero_a[i], m_res[i][8]);
        check($sformatf("ovf[D%0d]", 1 << i),  ovf_a[i],  m_res[i][9]);
        check($sformatf("bout[D%0d]", 1 << i), bout_a[i], m_res[i][10]);
      end
    end
  end

  task automatic launch(input logic [7:0] xa, input logic [7:0] ya, input logic ba);
    x = xa; y = ya; bin = ba; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int limit, output int k);
    k = 0;
    while (done_a[idx] !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] ed, input logic eb,
                           input logic eo, input logic ez);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_d[D%0d]", tag, 1 << i),    d_a[i],    ed);
      check($sformatf("%s_bout[D%0d]", tag, 1 << i), bout_a[i], eb);
      check($sformatf("%s_ovf[D%0d]", tag, 1 << i),  ovf_a[i],  eo);
      check($sformatf("%s_zero[D%0d]", tag, 1 << i), zero_a[i], ez);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                        input logic ba, input logic [7:0] ed, input logic eb,
                        input logic eo, input logic ez);
    int k;
    launch(xa, ya, ba);
    check({tag, "_busy"}, busy_a[0], 1'b1);
    wait_done(0, 40, k);
    check({tag, "_latency"}, k, 8);
    check_res(tag, ed, eb, eo, ez);
    @(negedge clk);
  endtask

  initial begin
    int k, ndone, base, cyc;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_busy[D%0d]", 1 << i), busy_a[i], 1'b0);
      check($sformatf("rst_done[D%0d]", 1 << i), done_a[i], 1'b0);
    end
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    check("t1_model_d", m_res[0][7:0], 8'h1E);
    run_op("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("t2b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("t3a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("t3b", 8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("t3c", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Starts during RUN and DONE are dropped; restart lands at the earliest edge.
    launch(8'h5A, 8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    x = 8'hFF; y = 8'h01; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_after_ignored", busy_a[0], 1'b1);
    ndone = 0;
    for (int kk = 3; kk < 8; kk++) begin
      @(negedge clk);
      if (done_a[0] === 1'b1) ndone++;
    end
    check("t4_single_done", ndone, 1);
    check("t4_d", d_a[0], 8'h1E);
    x = 8'h12; y = 8'h34; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    check("t4_done_ignores_start_busy", busy_a[0], 1'b0);
    check("t4_done_ignores_start_done", done_a[0], 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t4_restart", busy_a[0], 1'b1);
    wait_done(0, 40, k);
    check("t4_restart_latency", k, 8);
    check_res("t4", 8'hDE, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Reset mid-run clears everything and suppresses the pending done.
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("t5_busy[D%0d]", 1 << i), busy_a[i], 1'b0);
      check($sformatf("t5_done[D%0d]", 1 << i), done_a[i], 1'b0);
    end
    check_res("t5", 8'h00, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    for (int kk = 0; kk < 12; kk++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (done_a[i] === 1'b1) ndone++;
    end
    check("t5_no_done_after_rst", ndone, 0);
    run_op("t5_fresh", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);

    // DIGIT=4 instance finishes two edges after acceptance.
    launch(8'hA7, 8'h58, 1'b0);
    wait_done(2, 20, k);
    check("t6_latency_d4", k, 2);
    check("t6_d_d4", d_a[2], 8'h4F);
    check("t6_bout_d4", bout_a[2], 1'b0);
    check("t6_ovf_d4", ovf_a[2], 1'b1);
    wait_done(0, 40, k);
    check("t6_latency_d1", k, 6);
    check_res("t6", 8'h4F, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Random operands, random start density, rare resets.
    base = n_acc0;
    cyc  = 0;
    while ((n_acc0 - base) < 1000 && cyc < 30000) begin
      x     = 8'($urandom);
      y     = 8'($urandom);
      bin   = 1'($urandom);
      start = ($urandom_range(3) != 0);
      rst   = ($urandom_range(199) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rst   = 1'b0;
    check("random_ops_accepted", (n_acc0 - base) >= 1000, 1'b1);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
